// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - registered N-channel valid/ready multiplexer with fixed or round-robin select
//
// Purpose:
//   Chooses one of NCH producer channels and registers its beat into a single
//   output stage (1-cycle latency, full throughput). mode=0 picks channel
//   `sel`; mode=1 arbitrates round-robin starting at an internal pointer.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   mode       in   1          0 = fixed select, 1 = round-robin
//   sel        in   SELW       channel index for fixed mode
//   in_data    in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel request
//   in_ready   out  NCH        per-channel accept (at most one bit set)
//   out_data   out  WIDTH      registered selected data
//   out_ch     out  SELW       channel that supplied out_data
//   out_valid  out  1          output stage holds a beat
//   out_ready  in   1          consumer accepts the beat

module arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load_en;
    logic [NCH-1:0]   grant;
    logic             xfer;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    // The output stage can take a new beat when empty or being drained now.
    assign load_en = !out_valid_q || out_ready;

    // Grant: one-hot or zero. Round-robin walks from rr_ptr, wrapping at NCH.
    always_comb begin
        logic [SELW-1:0] idx;
        logic            found;
        grant = '0;
        found = 1'b0;
        idx   = rr_ptr_q;
        if (mode) begin
            for (int k = 0; k < NCH; k++) begin
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
                idx = (idx == LAST_CH) ? '0 : idx + SELW'(1);
            end
        end else if (int'(sel) < NCH) begin
            // Out-of-range select simply grants nothing.
            grant[sel] = in_valid[sel];
        end
    end

    // in_ready is held low during reset so no producer sees a phantom accept.
    assign in_ready = (reset || !load_en) ? '0 : grant;
    assign xfer     = |in_ready;

    // Encode the granted channel and pick its data.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                gnt_idx  = SELW'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state for the output stage and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            // Load wins over drain, so a simultaneous drain+load has no bubble.
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SELW'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - directed scoreboard bench for arb_mux

module tb_arb_mux;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic [1:0]   sel;
    logic [31:0]  chd [4];
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    logic [1:0]   sel3;
    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_ch3;
    logic         out_valid3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  ch;
    } beat_t;

    beat_t exp_q [$];
    int    n_assert = 0;
    int    n_fail   = 0;

    assign in_data  = {chd[3], chd[2], chd[1], chd[0]};
    assign in_data3 = {chd[2], chd[1], chd[0]};

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(32), .NCH(4), .SELW(2)) dut4 (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(32), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch);
        beat_t b;
        b.data = chd[ch];
        b.ch   = 2'(ch);
        exp_q.push_back(b);
    endtask

    task automatic chk_beat(input string tag);
        beat_t b;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: observed beat with empty scoreboard expected none", tag);
        end else begin
            b = exp_q.pop_front();
            chk({tag, ".valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".data"},  64'(out_data),  64'(b.data));
            chk({tag, ".ch"},    64'(out_ch),    64'(b.ch));
        end
    endtask

    initial begin
        chd[0] = 32'hA000_0000; chd[1] = 32'hA111_1111;
        chd[2] = 32'hA222_2222; chd[3] = 32'hA333_3333;
        reset = 1'b1; mode = 1'b1; sel = 2'd0; sel3 = 2'd3;
        in_valid = 4'b1111; in_valid3 = 3'b111; out_ready = 1'b1;

        // Reset held two cycles with every channel requesting.
        tick(); tick();
        chk("rst.valid",    64'(out_valid), 64'd0);
        chk("rst.data",     64'(out_data),  64'd0);
        chk("rst.ch",       64'(out_ch),    64'd0);
        chk("rst.in_ready", 64'(in_ready),  64'd0);
        chk("rst.ready3",   64'(in_ready3), 64'd0);

        // First edge after release loads channel 0 in round-robin.
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", 64'(in_ready), 64'b0001);
        push(0); tick(); chk_beat("post_rst");

        // Fixed mode, sel=2 with distinct marker data.
        mode = 1'b0; sel = 2'd2; chd[2] = 32'hDEAD_BEEF;
        #1;
        chk("fix2.in_ready", 64'(in_ready), 64'b0100);
        push(2); tick(); chk_beat("fix2");

        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("sweep%0d.in_ready", s), 64'(in_ready), 64'(4'b0001 << s));
            push(s); tick(); chk_beat($sformatf("sweep%0d", s));
        end

        // Round-robin: pointer is still 1 (fixed mode leaves it). Grant ch3 alone to wrap it to 0.
        mode = 1'b1; in_valid = 4'b1000;
        #1;
        chk("rr_pre.in_ready", 64'(in_ready), 64'b1000);
        push(3); tick(); chk_beat("rr_pre");

        in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            push(c % 4); tick(); chk_beat($sformatf("rr_fair%0d", c));
        end

        // Sparse round-robin with wrap.
        in_valid = 4'b0100; push(2); tick(); chk_beat("sparse_ch2");
        in_valid = 4'b0010; push(1); tick(); chk_beat("sparse_ch1");
        in_valid = 4'b1001;
        #1;
        chk("sparse_30.in_ready", 64'(in_ready), 64'b1000);
        push(3); tick(); chk_beat("sparse_ch3");
        push(0); tick(); chk_beat("sparse_ch0");

        // Backpressure: hold a ch1 beat for three cycles.
        chd[1] = 32'h0000_0011; in_valid = 4'b0010;
        push(1); tick(); chk_beat("bp_load");
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d.in_ready", c), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("bp%0d.data", c),  64'(out_data),  64'h11);
            chk($sformatf("bp%0d.ch", c),    64'(out_ch),    64'd1);
            chk($sformatf("bp%0d.valid", c), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", 64'(in_ready), 64'b0100);
        push(2); tick(); chk_beat("bp_release");

        // Drain with no requests: valid drops, data held.
        in_valid = 4'b0000; tick();
        chk("drain.valid", 64'(out_valid), 64'd0);
        chk("drain.data",  64'(out_data),  64'hDEAD_BEEF);

        // Reset mid-operation drops the held beat.
        in_valid = 4'b0001; push(0); tick(); chk_beat("mid_load");
        out_ready = 1'b0; reset = 1'b1;
        #1;
        chk("mid_rst.in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("mid_rst.valid", 64'(out_valid), 64'd0);
        chk("mid_rst.data",  64'(out_data),  64'd0);
        reset = 1'b0; in_valid = 4'b0000; out_ready = 1'b1; tick();
        chk("mid_rst.lost", 64'(out_valid), 64'd0);

        // NCH=3 instance: out-of-range sel grants nothing, in-range works.
        mode = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        chk("n3_sel3.in_ready", 64'(in_ready3), 64'd0);
        tick();
        chk("n3_sel3.valid", 64'(out_valid3), 64'd0);
        sel3 = 2'd1;
        #1;
        chk("n3_sel1.in_ready", 64'(in_ready3), 64'b010);
        tick();
        chk("n3_sel1.valid", 64'(out_valid3), 64'd1);
        chk("n3_sel1.data",  64'(out_data3),  64'h11);
        chk("n3_sel1.ch",    64'(out_ch3),    64'd1);

        chk("scoreboard.empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
